// File: rtl/z16_pkg.sv
// ============================================================================
// z16_pkg : shared widths and types for the Z16 writeback slice
// Rev 1.0
// ============================================================================
`default_nettype none

package z16_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;
endpackage

`default_nettype wire

// File: rtl/z16_ld_tag_fifo.sv
// ============================================================================
// z16_ld_tag_fifo : synchronous FIFO of destination tags for in-flight loads
// Rev 1.0
// ============================================================================
`default_nettype none

module z16_ld_tag_fifo
  import z16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  reg_addr_t i_push_tag,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output reg_addr_t o_head
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when low bits match.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  reg_addr_t   mem_q [DEPTH];

  always_comb begin
    o_empty = (wptr_q == rptr_q);
    o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    o_head  = mem_q[rptr_q[AW-1:0]];
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (i_push && !o_full) wptr_d = wptr_q + 1'b1;
    if (i_pop && !o_empty) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_push && !o_full) mem_q[wptr_q[AW-1:0]] <= i_push_tag;
  end
endmodule

`default_nettype wire

// File: rtl/z16_writeback.sv
// ============================================================================
// z16_writeback : ALU/load write arbiter, busy scoreboard and RF write register
// Optional read bypass mux enabled by Z16_WB_BYPASS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module z16_writeback
  import z16_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  output logic        o_alu_ready,
  input  logic [3:0]  i_alu_rd_addr,
  input  logic [15:0] i_alu_data,
  input  logic        i_ld_req_valid,
  output logic        o_ld_req_ready,
  input  logic [3:0]  i_ld_req_rd_addr,
  input  logic        i_ld_rsp_valid,
  input  logic [15:0] i_ld_rsp_data,
`ifdef Z16_WB_BYPASS_EN
  input  logic [3:0]  i_rs1_addr,
  input  logic [3:0]  i_rs2_addr,
  input  logic [15:0] i_rs1_rf_data,
  input  logic [15:0] i_rs2_rf_data,
  output logic [15:0] o_rs1_data,
  output logic [15:0] o_rs2_data,
`endif
  output logic        o_rd_wen,
  output logic [3:0]  o_rd_addr,
  output logic [15:0] o_rd_data,
  output logic [15:0] o_busy_mask,
  output logic        o_err
);
  logic                fifo_full, fifo_empty;
  reg_addr_t           fifo_head;
  logic                ld_wr, ld_push, alu_acc;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                rd_wen_q, rd_wen_d;
  reg_addr_t           rd_addr_q, rd_addr_d;
  word_t               rd_data_q, rd_data_d;
  logic                err_q, err_d;

  z16_ld_tag_fifo #(.DEPTH(LD_DEPTH)) u_tag_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (ld_push),
    .i_push_tag (i_ld_req_rd_addr),
    .i_pop      (ld_wr),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_head     (fifo_head)
  );

  // Load responses always win the write port since they cannot be stalled.
  always_comb begin
    ld_wr          = i_ld_rsp_valid && !fifo_empty;
    o_alu_ready    = !i_rst && !ld_wr && !busy_q[i_alu_rd_addr];
    o_ld_req_ready = !i_rst && !fifo_full && !busy_q[i_ld_req_rd_addr];
    alu_acc        = i_alu_valid && o_alu_ready;
    ld_push        = i_ld_req_valid && o_ld_req_ready;
  end

  always_comb begin
    busy_d    = busy_q;
    rd_wen_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    err_d     = err_q || (i_ld_rsp_valid && fifo_empty);
    if (ld_push) busy_d[i_ld_req_rd_addr] = 1'b1;
    if (ld_wr) begin
      busy_d[fifo_head] = 1'b0;
      rd_wen_d          = 1'b1;
      rd_addr_d         = fifo_head;
      rd_data_d         = i_ld_rsp_data;
    end else if (alu_acc) begin
      rd_wen_d  = 1'b1;
      rd_addr_d = i_alu_rd_addr;
      rd_data_d = i_alu_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q    <= '0;
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rd_wen_q  <= rd_wen_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    o_rd_wen    = rd_wen_q;
    o_rd_addr   = rd_addr_q;
    o_rd_data   = rd_data_q;
    o_busy_mask = busy_q;
    o_err       = err_q;
  end

`ifdef Z16_WB_BYPASS_EN
  // Forward the value being written this cycle to same-cycle register reads.
  always_comb begin
    o_rs1_data = (rd_wen_q && rd_addr_q == i_rs1_addr) ? rd_data_q : i_rs1_rf_data;
    o_rs2_data = (rd_wen_q && rd_addr_q == i_rs2_addr) ? rd_data_q : i_rs2_rf_data;
  end
`endif
endmodule

`default_nettype wire
